// File: rtl/ttt_pkg.sv
// ttt_pkg: shared tic-tac-toe definitions for the board array, button FSM and CPU player.
package ttt_pkg;
    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] X     = 2'b01;
    localparam logic [1:0] O     = 2'b10;

    typedef enum logic [1:0] {IDLE, READ, EVAL, COMMIT} state_t;

    localparam logic [3:0] LINES [8][3] = '{
        '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
    };

    // Fallback move order: centre, corners, edges.
    localparam logic [3:0] PREF [9] = '{4'd4, 4'd0, 4'd2, 4'd6, 4'd8, 4'd1, 4'd3, 4'd5, 4'd7};
endpackage

// File: rtl/line_eval.sv
// line_eval: classifies one three-cell line as a CPU or human two-in-a-row with one gap.
module line_eval
    import ttt_pkg::*;
(
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    input  logic [1:0] c_i,
    input  logic [1:0] cpu_mark_i,
    input  logic [1:0] human_mark_i,
    output logic       cpu_two_o,
    output logic       human_two_o,
    output logic       empty_vld_o,
    output logic [1:0] empty_pos_o
);
    logic [1:0] n_cpu, n_hum, n_emp;

    always_comb begin
        n_cpu = 2'(a_i == cpu_mark_i) + 2'(b_i == cpu_mark_i) + 2'(c_i == cpu_mark_i);
        n_hum = 2'(a_i == human_mark_i) + 2'(b_i == human_mark_i) + 2'(c_i == human_mark_i);
        n_emp = 2'(a_i == EMPTY) + 2'(b_i == EMPTY) + 2'(c_i == EMPTY);
        cpu_two_o   = (n_cpu == 2'd2) && (n_emp == 2'd1);
        human_two_o = (n_hum == 2'd2) && (n_emp == 2'd1);
        empty_vld_o = n_emp != 2'd0;
        empty_pos_o = (a_i == EMPTY) ? 2'd0 : (b_i == EMPTY) ? 2'd1 : 2'd2;
    end
endmodule

// File: rtl/cpu_player.sv
// cpu_player: computer opponent; snapshots the board, scans the eight lines,
// then writes one mark chosen by win > block > centre > corners > edges.
module cpu_player
    import ttt_pkg::*;
#(
    parameter logic [1:0] CPU_MARK   = O,
    parameter logic [1:0] HUMAN_MARK = X
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       go,
    input  logic       game_over,
    output logic [3:0] rd_addr,
    input  logic [1:0] rd_data,
    output logic       wr_en,
    output logic [3:0] wr_addr,
    output logic [1:0] wr_data,
    output logic       busy,
    output logic       done,
    output logic       no_move
);
    state_t     state_q;
    logic       go_q, win_vld_q, blk_vld_q, wr_en_q, done_q, no_move_q;
    logic [3:0] k_q, win_q, blk_q, rd_addr_q, wr_addr_q;
    logic [2:0] line_q;
    logic [1:0] cell_q [9];
    logic [1:0] wr_data_q;
    logic       cpu_two, human_two, emp_vld, win_vld_d, blk_vld_d, pick_vld;
    logic [1:0] emp_pos;
    logic [3:0] hit_cell, win_d, blk_d, pick;

    line_eval u_line (
        .a_i         (cell_q[LINES[line_q][0]]),
        .b_i         (cell_q[LINES[line_q][1]]),
        .c_i         (cell_q[LINES[line_q][2]]),
        .cpu_mark_i  (CPU_MARK),
        .human_mark_i(HUMAN_MARK),
        .cpu_two_o   (cpu_two),
        .human_two_o (human_two),
        .empty_vld_o (emp_vld),
        .empty_pos_o (emp_pos)
    );

    // Merge the current line so the final EVAL cycle can register the choice directly.
    always_comb begin
        hit_cell  = LINES[line_q][emp_pos];
        win_vld_d = win_vld_q | (cpu_two & emp_vld);
        blk_vld_d = blk_vld_q | (human_two & emp_vld);
        win_d     = win_vld_q ? win_q : hit_cell;
        blk_d     = blk_vld_q ? blk_q : hit_cell;
        pick      = 4'd0;
        pick_vld  = 1'b0;
        for (int i = 8; i >= 0; i--)
            if (cell_q[PREF[i]] == EMPTY) begin
                pick     = PREF[i];
                pick_vld = 1'b1;
            end
        if (blk_vld_d) pick = blk_d;
        if (win_vld_d) pick = win_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            go_q      <= 1'b0;
            k_q       <= 4'd0;
            line_q    <= 3'd0;
            cell_q    <= '{default: EMPTY};
            win_q     <= 4'd0;
            blk_q     <= 4'd0;
            win_vld_q <= 1'b0;
            blk_vld_q <= 1'b0;
            rd_addr_q <= 4'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 4'd0;
            wr_data_q <= 2'b00;
            done_q    <= 1'b0;
            no_move_q <= 1'b0;
        end else if (game_over) begin
            state_q   <= IDLE;
            go_q      <= 1'b0;
            rd_addr_q <= 4'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 4'd0;
            wr_data_q <= 2'b00;
            done_q    <= 1'b0;
            no_move_q <= 1'b0;
        end else begin
            go_q      <= go && (state_q == IDLE) && !go_q;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 4'd0;
            wr_data_q <= 2'b00;
            done_q    <= 1'b0;
            no_move_q <= 1'b0;
            case (state_q)
                IDLE: if (go_q) begin
                    state_q   <= READ;
                    k_q       <= 4'd0;
                    rd_addr_q <= 4'd0;
                    win_vld_q <= 1'b0;
                    blk_vld_q <= 1'b0;
                end
                READ: begin
                    if (k_q != 4'd0) cell_q[k_q - 4'd1] <= rd_data;
                    k_q       <= k_q + 4'd1;
                    rd_addr_q <= (k_q >= 4'd8) ? 4'd8 : k_q + 4'd1;
                    if (k_q == 4'd9) begin
                        state_q   <= EVAL;
                        line_q    <= 3'd0;
                        rd_addr_q <= 4'd0;
                    end
                end
                EVAL: begin
                    win_q     <= win_d;
                    blk_q     <= blk_d;
                    win_vld_q <= win_vld_d;
                    blk_vld_q <= blk_vld_d;
                    line_q    <= line_q + 3'd1;
                    if (line_q == 3'd7) begin
                        state_q   <= COMMIT;
                        wr_en_q   <= pick_vld;
                        wr_addr_q <= pick_vld ? pick : 4'd0;
                        wr_data_q <= pick_vld ? CPU_MARK : 2'b00;
                        done_q    <= 1'b1;
                        no_move_q <= !pick_vld;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd_addr = rd_addr_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = state_q != IDLE;
    assign done    = done_q;
    assign no_move = no_move_q;
endmodule
